// File: rtl/emac_host_arbiter.sv
// emac_host_arbiter
//   Shares one EMAC host management interface (config registers and MIIM/MDIO)
//   between two requesters. Requests are granted round-robin, sequenced onto
//   the HOST* pins, and each completion is returned to the requester that
//   issued it. MIIM accesses are bounded by a timeout counter.
//
// Ports
//   HOSTCLK, RESET        clock (rising edge), asynchronous active-high reset
//   rqN_valid/ready       request handshake (N = 0,1), ready is combinational
//   rqN_miim/write        access kind: MIIM or config, write or read
//   rqN_emac1sel          target EMAC1 (1) or EMAC0 (0)
//   rqN_addr/wdata        config address or {phyad,regad}; write data
//   rspN_valid            one-cycle completion pulse
//   rspN_rdata/timeout    read data and MIIM timeout flag, valid with rspN_valid
//   HOSTOPCODE/REQ/MIIMSEL/EMAC1SEL/ADDR/WRDATA   registered EMAC host outputs
//   HOSTRDDATA, HOSTMIIMRDY                       EMAC host inputs
//   busy                  arbiter is not idle

module emac_host_arbiter #(
  parameter int TMO_W        = 12,
  parameter int MIIM_TIMEOUT = 4000
) (
  input  logic        HOSTCLK,
  input  logic        RESET,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic        rq0_miim,
  input  logic        rq0_write,
  input  logic        rq0_emac1sel,
  input  logic [9:0]  rq0_addr,
  input  logic [31:0] rq0_wdata,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic        rq1_miim,
  input  logic        rq1_write,
  input  logic        rq1_emac1sel,
  input  logic [9:0]  rq1_addr,
  input  logic [31:0] rq1_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_timeout,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_timeout,
  output logic [1:0]  HOSTOPCODE,
  output logic        HOSTREQ,
  output logic        HOSTMIIMSEL,
  output logic        HOSTEMAC1SEL,
  output logic [9:0]  HOSTADDR,
  output logic [31:0] HOSTWRDATA,
  input  logic [31:0] HOSTRDDATA,
  input  logic        HOSTMIIMRDY,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_ISSUE, S_CFG_WAIT, S_MIIM_PRE, S_MIIM_ISSUE, S_MIIM_WAIT, S_RESP
  } state_t;

  // The timeout fires in the cycle that would bring the count to MIIM_TIMEOUT.
  // A ">=" compare keeps the bound even if the count passed the limit while
  // MIIM_PRE was being left on a ready/timeout tie.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MIIM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        lastSrv_q, lastSrv_d;
  logic        owner_q, owner_d;
  logic        miim_q, miim_d;
  logic        write_q, write_d;
  logic        emac1_q, emac1_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [TMO_W-1:0] cnt_q, cnt_d, cntInc;
  logic        firstWait_q;
  logic        tmoHit;
  logic        grant0, grant1;
  logic        rspLoad;
  logic [31:0] rspRdata_d;
  logic        rspTmo_d;

  logic [1:0]  hostOpcode_q, hostOpcode_d;
  logic        hostReq_q, hostReq_d;
  logic        hostMiimSel_q, hostMiimSel_d;
  logic        hostEmac1Sel_q, hostEmac1Sel_d;
  logic [9:0]  hostAddr_q, hostAddr_d;
  logic [31:0] hostWrData_q, hostWrData_d;
  logic        rsp0Valid_q, rsp1Valid_q;
  logic [31:0] rsp0Rdata_q, rsp1Rdata_q;
  logic        rsp0Tmo_q, rsp1Tmo_q;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  assign grant0    = rq0_valid & (~rq1_valid | lastSrv_q);
  assign grant1    = rq1_valid & (~rq0_valid | ~lastSrv_q);
  assign rq0_ready = (state_q == S_IDLE) & grant0;
  assign rq1_ready = (state_q == S_IDLE) & grant1;
  assign busy      = (state_q != S_IDLE);

  assign cntInc = (cnt_q == {TMO_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign tmoHit = (cnt_q >= TMO_LAST);

  // Next-state logic: acceptance, transaction sequencing and response capture.
  always_comb begin
    state_d    = state_q;
    lastSrv_d  = lastSrv_q;
    owner_d    = owner_q;
    miim_d     = miim_q;
    write_d    = write_q;
    emac1_d    = emac1_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rspLoad    = 1'b0;
    rspRdata_d = 32'h0;
    rspTmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant0 | grant1) begin
          owner_d   = grant1;
          lastSrv_d = grant1;
          miim_d    = grant1 ? rq1_miim     : rq0_miim;
          write_d   = grant1 ? rq1_write    : rq0_write;
          emac1_d   = grant1 ? rq1_emac1sel : rq0_emac1sel;
          addr_d    = grant1 ? rq1_addr     : rq0_addr;
          wdata_d   = grant1 ? rq1_wdata    : rq0_wdata;
          cnt_d     = '0;
          state_d   = miim_d ? S_MIIM_PRE : S_CFG_ISSUE;
        end
      end
      S_CFG_ISSUE: state_d = S_CFG_WAIT;
      S_CFG_WAIT: begin
        rspLoad    = 1'b1;
        rspRdata_d = write_q ? 32'h0 : HOSTRDDATA;
        state_d    = S_RESP;
      end
      S_MIIM_PRE: begin
        cnt_d = cntInc;
        if (HOSTMIIMRDY) begin
          state_d = S_MIIM_ISSUE;
        end else if (tmoHit) begin
          rspLoad  = 1'b1;
          rspTmo_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_MIIM_ISSUE: state_d = S_MIIM_WAIT;
      S_MIIM_WAIT: begin
        cnt_d = cntInc;
        // RDY is still showing the previous idle level on the first cycle.
        if (!firstWait_q && HOSTMIIMRDY) begin
          rspLoad    = 1'b1;
          rspRdata_d = write_q ? 32'h0 : {16'h0, HOSTRDDATA[15:0]};
          state_d    = S_RESP;
        end else if (tmoHit) begin
          rspLoad  = 1'b1;
          rspTmo_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Host outputs are decoded from the next state so the registered pins line
  // up with the state they belong to.
  always_comb begin
    hostOpcode_d   = 2'b00;
    hostReq_d      = 1'b0;
    hostMiimSel_d  = 1'b0;
    hostEmac1Sel_d = 1'b0;
    hostAddr_d     = 10'h0;
    hostWrData_d   = 32'h0;
    case (state_d)
      S_CFG_ISSUE: begin
        hostEmac1Sel_d = emac1_d;
        hostOpcode_d   = {~write_d, 1'b0};
        hostAddr_d     = addr_d;
        hostWrData_d   = wdata_d;
      end
      S_CFG_WAIT: hostEmac1Sel_d = emac1_d;
      S_MIIM_PRE, S_MIIM_WAIT: begin
        hostMiimSel_d  = 1'b1;
        hostEmac1Sel_d = emac1_d;
      end
      S_MIIM_ISSUE: begin
        hostMiimSel_d  = 1'b1;
        hostEmac1Sel_d = emac1_d;
        hostReq_d      = 1'b1;
        hostOpcode_d   = write_d ? 2'b01 : 2'b10;
        hostAddr_d     = addr_d;
        hostWrData_d   = {16'h0, wdata_d[15:0]};
      end
      default: ;
    endcase
  end

  // State, latched request, timeout counter and registered outputs. Only the
  // serviced requester's response fields are loaded.
  always_ff @(posedge HOSTCLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      lastSrv_q      <= 1'b1;
      owner_q        <= 1'b0;
      miim_q         <= 1'b0;
      write_q        <= 1'b0;
      emac1_q        <= 1'b0;
      addr_q         <= 10'h0;
      wdata_q        <= 32'h0;
      cnt_q          <= '0;
      firstWait_q    <= 1'b0;
      hostOpcode_q   <= 2'b00;
      hostReq_q      <= 1'b0;
      hostMiimSel_q  <= 1'b0;
      hostEmac1Sel_q <= 1'b0;
      hostAddr_q     <= 10'h0;
      hostWrData_q   <= 32'h0;
      rsp0Valid_q    <= 1'b0;
      rsp0Rdata_q    <= 32'h0;
      rsp0Tmo_q      <= 1'b0;
      rsp1Valid_q    <= 1'b0;
      rsp1Rdata_q    <= 32'h0;
      rsp1Tmo_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lastSrv_q      <= lastSrv_d;
      owner_q        <= owner_d;
      miim_q         <= miim_d;
      write_q        <= write_d;
      emac1_q        <= emac1_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      firstWait_q    <= (state_q == S_MIIM_ISSUE);
      hostOpcode_q   <= hostOpcode_d;
      hostReq_q      <= hostReq_d;
      hostMiimSel_q  <= hostMiimSel_d;
      hostEmac1Sel_q <= hostEmac1Sel_d;
      hostAddr_q     <= hostAddr_d;
      hostWrData_q   <= hostWrData_d;
      rsp0Valid_q    <= rspLoad & ~owner_q;
      rsp1Valid_q    <= rspLoad & owner_q;
      if (rspLoad & ~owner_q) begin
        rsp0Rdata_q <= rspRdata_d;
        rsp0Tmo_q   <= rspTmo_d;
      end
      if (rspLoad & owner_q) begin
        rsp1Rdata_q <= rspRdata_d;
        rsp1Tmo_q   <= rspTmo_d;
      end
    end
  end

  assign HOSTOPCODE   = hostOpcode_q;
  assign HOSTREQ      = hostReq_q;
  assign HOSTMIIMSEL  = hostMiimSel_q;
  assign HOSTEMAC1SEL = hostEmac1Sel_q;
  assign HOSTADDR     = hostAddr_q;
  assign HOSTWRDATA   = hostWrData_q;
  assign rsp0_valid   = rsp0Valid_q;
  assign rsp0_rdata   = rsp0Rdata_q;
  assign rsp0_timeout = rsp0Tmo_q;
  assign rsp1_valid   = rsp1Valid_q;
  assign rsp1_rdata   = rsp1Rdata_q;
  assign rsp1_timeout = rsp1Tmo_q;

endmodule
